// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator car controller.
package elevator_pkg;

    localparam int DEF_FLOOR_W       = 3;
    localparam int DEF_NUM_FLOORS    = 6;
    localparam int DEF_TRAVEL_CYCLES = 4;
    localparam int DEF_DOOR_CYCLES   = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } car_state_t;

    typedef logic [DEF_FLOOR_W-1:0] floor_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by travel and door-dwell phases.
// Load wins over decrement; the count parks at zero.
module elevator_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Count register: reload on request, otherwise count down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mag_cmp.sv
// Unsigned magnitude comparator: gt is high when a > b.
module mag_cmp #(
    parameter int W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt
);

    assign gt = (a > b);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Motion and door controller for a single elevator car.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | parked with door closed, ready for a target floor
// MOVE_UP   | travelling up one floor per TRAVEL_CYCLES
// MOVE_DOWN | travelling down one floor per TRAVEL_CYCLES
// DOOR_OPEN | door open at the target for DOOR_CYCLES
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOOR_W       = DEF_FLOOR_W,
    parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
    parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
    output logic               req_ready,
    output logic               req_err,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               moving_up,
    output logic               moving_down,
    output logic               door_open,
    output logic               arrived
);

    localparam int TMR_W = $clog2(max2(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
    localparam logic [TMR_W-1:0] TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0] DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);
    // One extra bit so NUM_FLOORS == 2**FLOOR_W stays representable.
    localparam logic [FLOOR_W:0] FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

    car_state_t         state, state_nxt;
    logic [FLOOR_W-1:0] target, target_nxt;
    logic [FLOOR_W-1:0] floor_nxt;
    logic               err_nxt, arr_nxt;
    logic               tmr_load, tmr_zero;
    logic [TMR_W-1:0]   tmr_val;
    logic               req_above, req_below, req_bad;
    logic [FLOOR_W-1:0] floor_up, floor_dn;

    mag_cmp #(.W(FLOOR_W)) u_cmp_above (
        .a  (req_floor),
        .b  (cur_floor),
        .gt (req_above)
    );

    mag_cmp #(.W(FLOOR_W)) u_cmp_below (
        .a  (cur_floor),
        .b  (req_floor),
        .gt (req_below)
    );

    elevator_timer #(.W(TMR_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_val),
        .zero  (tmr_zero)
    );

    assign req_bad  = ({1'b0, req_floor} >= FLOOR_LIMIT);
    assign floor_up = cur_floor + FLOOR_W'(1);
    assign floor_dn = cur_floor - FLOOR_W'(1);

    // State, position and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_floor <= '0;
            target    <= '0;
            req_err   <= 1'b0;
            arrived   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_floor <= floor_nxt;
            target    <= target_nxt;
            req_err   <= err_nxt;
            arrived   <= arr_nxt;
        end
    end

    // Next-state, floor stepping and timer control.
    always_comb begin
        state_nxt  = state;
        floor_nxt  = cur_floor;
        target_nxt = target;
        err_nxt    = 1'b0;
        arr_nxt    = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        target_nxt = req_floor;
                        tmr_load   = 1'b1;
                        if (req_above) begin
                            state_nxt = MOVE_UP;
                            tmr_val   = TRAVEL_LOAD;
                        end else if (req_below) begin
                            state_nxt = MOVE_DOWN;
                            tmr_val   = TRAVEL_LOAD;
                        end else begin
                            state_nxt = DOOR_OPEN;
                            tmr_val   = DOOR_LOAD;
                            arr_nxt   = 1'b1;
                        end
                    end
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (tmr_zero) begin
                    floor_nxt = (state == MOVE_UP) ? floor_up : floor_dn;
                    tmr_load  = 1'b1;
                    if (floor_nxt == target) begin
                        state_nxt = DOOR_OPEN;
                        tmr_val   = DOOR_LOAD;
                        arr_nxt   = 1'b1;
                    end else begin
                        tmr_val   = TRAVEL_LOAD;
                    end
                end
            end
            DOOR_OPEN: begin
                if (tmr_zero) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready   = (state == IDLE);
    assign moving_up   = (state == MOVE_UP);
    assign moving_down = (state == MOVE_DOWN);
    assign door_open   = (state == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Bench for elevator_car_ctrl: expected per-cycle output vectors are queued
// when a request is driven and popped one per cycle against the DUT.
module tb_elevator_car_ctrl;
    import elevator_pkg::*;

    localparam int NF = 6;
    localparam int TC = 4;
    localparam int DC = 3;

    logic   clk = 1'b0;
    logic   reset;
    logic   req_valid;
    floor_t req_floor;
    logic   req_ready, req_err, moving_up, moving_down, door_open, arrived;
    floor_t cur_floor;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];

    elevator_car_ctrl #(
        .FLOOR_W       (3),
        .NUM_FLOORS    (NF),
        .TRAVEL_CYCLES (TC),
        .DOOR_CYCLES   (DC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_floor   (req_floor),
        .req_ready   (req_ready),
        .req_err     (req_err),
        .cur_floor   (cur_floor),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .arrived     (arrived)
    );

    always #5 clk = ~clk;

    // Vector layout: ready, err, floor[2:0], up, down, door, arrived
    function automatic logic [8:0] mk(input logic rdy, input logic err, input int fl,
                                      input logic up, input logic dn, input logic dr,
                                      input logic arr);
        return {rdy, err, 3'(fl), up, dn, dr, arr};
    endfunction

    function automatic logic [8:0] observed();
        return {req_ready, req_err, cur_floor, moving_up, moving_down, door_open, arrived};
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (rdy,err,floor,up,dn,door,arr)", tag, obs, exp);
        end
    endtask

    // Queue the expected outputs of one accepted request, from the cycle
    // after acceptance up to and including the first IDLE cycle.
    task automatic push_trip(input int from, input int to);
        if (to >= NF) begin
            exp_q.push_back(mk(1, 1, from, 0, 0, 0, 0));
            exp_q.push_back(mk(1, 0, from, 0, 0, 0, 0));
        end else begin
            int d = (to > from) ? to - from : from - to;
            for (int k = 0; k < d; k++) begin
                for (int c = 0; c < TC; c++) begin
                    if (to > from) exp_q.push_back(mk(0, 0, from + k, 1, 0, 0, 0));
                    else           exp_q.push_back(mk(0, 0, from - k, 0, 1, 0, 0));
                end
            end
            for (int c = 0; c < DC; c++)
                exp_q.push_back(mk(0, 0, to, 0, 0, 1, (c == 0)));
            exp_q.push_back(mk(1, 0, to, 0, 0, 0, 0));
        end
    endtask

    // Pop up to max_n entries, one per clock; after the first sample the
    // request inputs switch to (keep_valid, next_floor).
    task automatic drain(input string tag, input logic keep_valid, input int next_floor,
                         input int max_n);
        int n = 0;
        while (exp_q.size() > 0 && n < max_n) begin
            @(posedge clk); #1;
            check($sformatf("%s[%0d]", tag, n), observed(), exp_q.pop_front());
            if (n == 0) begin
                req_valid = keep_valid;
                req_floor = 3'(next_floor);
            end
            n++;
        end
    endtask

    task automatic request(input string tag, input int from, input int to);
        req_valid = 1'b1;
        req_floor = 3'(to);
        push_trip(from, to);
        drain(tag, 1'b0, 0, 1000);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_floor = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_state", observed(), mk(1, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        check("idle_after_reset", observed(), mk(1, 0, 0, 0, 0, 0, 0));

        request("up_0_3", 0, 3);
        request("down_3_1", 3, 1);
        request("same_1_1", 1, 1);
        request("bad_7", 1, 7);
        request("down_1_0", 1, 0);

        // Held request for floor 5 during a 0->2 trip waits for IDLE.
        req_valid = 1'b1;
        req_floor = 3'd2;
        push_trip(0, 2);
        drain("held_0_2", 1'b1, 5, 1000);
        push_trip(2, 5);
        drain("held_2_5", 1'b0, 0, 1000);

        // Reset while moving down past floor 2.
        req_valid = 1'b1;
        req_floor = 3'd0;
        push_trip(5, 0);
        drain("abort_5_0", 1'b0, 0, 3 * TC + 2);
        exp_q.delete();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_mid_move", observed(), mk(1, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        check("idle_after_abort", observed(), mk(1, 0, 0, 0, 0, 0, 0));

        request("up_after_abort", 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
Motion and door controller for one elevator car; it is the consumer of target-floor requests.
- Accepts one target floor at a time over a valid/ready handshake.
- Decides direction by magnitude comparison against the current floor.
- Steps the car floor by floor with a per-floor travel timer, opens the door for a fixed dwell, then returns to idle.
- Sits between the request scheduler (upstream) and the floor display / motor / door drivers (downstream).

Parameters:
FLOOR_W, 3, width of floor index
NUM_FLOORS, 6, number of valid floors (0..NUM_FLOORS-1); must be <= 2**FLOOR_W
TRAVEL_CYCLES, 4, clock cycles to move one floor (>=1)
DOOR_CYCLES, 3, clock cycles the door stays open (>=1)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  1  upstream has a target floor
req_floor  input  FLOOR_W  requested target floor
req_ready  output  1  controller can accept a request (IDLE only)
req_err  output  1  one-cycle pulse: accepted request was out of range and dropped
cur_floor  output  FLOOR_W  current car floor
moving_up  output  1  car travelling upward
moving_down  output  1  car travelling downward
door_open  output  1  door open
arrived  output  1  one-cycle pulse on the first DOOR_OPEN cycle

Behaviour:
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- All outputs are registered or decoded from registered state; there is no combinational path from req_* to any output.
- Reset (synchronous, active-high, wins over everything, including mid-move or mid-door):
  - state=IDLE, cur_floor=0, target=0, timer=0.
  - req_ready=1 on the first cycle after reset; all other outputs 0.
- Handshake: accept occurs on a posedge where state==IDLE and req_valid==1; target is latched from req_floor.
  - req_ready = (state==IDLE).
  - req_valid while not IDLE is ignored, not queued; upstream must hold it.
- Transition on accept (effective next cycle):
  - req_floor >= NUM_FLOORS: stay IDLE, req_err=1 for one cycle, no target change.
  - req_floor > cur_floor: MOVE_UP, timer loaded with TRAVEL_CYCLES-1.
  - req_floor < cur_floor: MOVE_DOWN, timer loaded with TRAVEL_CYCLES-1.
  - req_floor == cur_floor: DOOR_OPEN, arrived=1, timer loaded with DOOR_CYCLES-1.
- MOVE_UP / MOVE_DOWN:
  - moving_up / moving_down=1 for the whole state.
  - Timer decrements each cycle. On the cycle it reads 0, cur_floor ±1 at that edge.
  - If the new floor == target: go to DOOR_OPEN (arrived pulses on the first DOOR_OPEN cycle). Otherwise reload the timer and keep moving.
  - cur_floor never leaves 0..NUM_FLOORS-1; no wrap-around is possible because the target was range-checked.
- DOOR_OPEN: door_open=1. Timer counts DOOR_CYCLES cycles, then IDLE.
- Timing:
  - Travel of d floors: moving_* high for exactly d*TRAVEL_CYCLES cycles, starting the cycle after accept.
  - door_open high for exactly DOOR_CYCLES cycles.
  - req_ready returns the cycle after the door closes.
- Mutual exclusion invariant: moving_up, moving_down and door_open are never high together.

Decomposition:
- Package elevator_pkg holds:
  - typedef enum logic [1:0] car_state_t {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN};
  - typedef floor_t (logic [FLOOR_W-1:0]);
  - default constants for NUM_FLOORS, TRAVEL_CYCLES, DOOR_CYCLES.
- One sub-module, elevator_timer:
  - Loadable down-counter with load/value inputs and a zero flag.
  - Width is $clog2 of max(TRAVEL_CYCLES, DOOR_CYCLES)+1.
  - Instantiated once and shared by the move and door states.
- The direction decision uses the existing team magnitude comparator (A>B) instantiated twice: target>cur and cur>target.

Test Plan (defaults: NUM_FLOORS=6, TRAVEL_CYCLES=4, DOOR_CYCLES=3):
1. Assert reset 2 cycles, release -> cur_floor=0, req_ready=1, moving_up/moving_down/door_open/arrived/req_err=0.
2. From floor 0, req 3 for one cycle:
   - req_ready=0 next cycle; moving_up=1 for 12 cycles.
   - cur_floor steps 1,2,3 every 4 cycles; then arrived=1 pulse; door_open=1 for 3 cycles; then req_ready=1.
3. From floor 3, req 1 -> moving_down=1 for 8 cycles, cur_floor 2 then 1, door_open 3 cycles, moving_up never asserted.
4. From floor 1, req 1 -> next cycle door_open=1 with arrived=1, 3 cycles, no moving_* activity, cur_floor stays 1.
5. In IDLE, req 7 -> req_err=1 for exactly one cycle, state stays IDLE, cur_floor unchanged, req_ready stays 1.
6. Two overlapping cases:
   - req_valid held with req_floor=5 during a 0->2 trip: the request is ignored until IDLE, then accepted.
   - Reset asserted while moving at floor 2: next cycle cur_floor=0, all motion/door outputs 0, req_ready=1.
